// File: rtl/arbiter_n_to_1_request_pkg.sv
// Shared types for the N-to-1 memory request arbiter: packet layout, ID hierarchy
// levels, FSM encoding and the route.from stamping helper.
package arbiter_n_to_1_request_pkg;

    localparam int unsigned ID_W  = 16;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 8;

    localparam int unsigned ID_LEVEL_CU     = 0;
    localparam int unsigned ID_LEVEL_BUNDLE = 1;
    localparam int unsigned ID_LEVEL_LANE   = 2;
    localparam int unsigned ID_LEVEL_ENGINE = 3;
    localparam int unsigned ID_LEVEL_MODULE = 4;
    localparam int unsigned ID_LEVEL_NONE   = 5;

    typedef logic [0:0] arbiter_state_t;
    localparam arbiter_state_t IDLE  = 1'b0;
    localparam arbiter_state_t GRANT = 1'b1;

    typedef struct packed {
        logic [ID_W-1:0] id_cu;
        logic [ID_W-1:0] id_bundle;
        logic [ID_W-1:0] id_lane;
        logic [ID_W-1:0] id_engine;
        logic [ID_W-1:0] id_module;
    } route_id_t;

    typedef struct packed {
        route_id_t from;
    } route_t;

    typedef struct packed {
        route_t      route;
        logic [31:0] address;
        logic [1:0]  cmd;
    } meta_t;

    typedef struct packed {
        meta_t       meta;
        logic [31:0] data;
    } payload_t;

    typedef struct packed {
        logic     valid;
        payload_t payload;
    } memory_packet_t;

    // Overwrites one route.from field; levels outside 0..4 leave the payload untouched.
    function automatic payload_t stamp_route_from(input payload_t p, input int unsigned level,
                                                  input logic [ID_W-1:0] id);
        payload_t r;
        r = p;
        case (level)
            ID_LEVEL_CU:     r.meta.route.from.id_cu     = id;
            ID_LEVEL_BUNDLE: r.meta.route.from.id_bundle = id;
            ID_LEVEL_LANE:   r.meta.route.from.id_lane   = id;
            ID_LEVEL_ENGINE: r.meta.route.from.id_engine = id;
            ID_LEVEL_MODULE: r.meta.route.from.id_module = id;
            default:         r = p;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/arbiter_n_to_1_request_rr_encoder.sv
// Combinational round-robin priority encoder: first set request after last_winner,
// wrapping modulo NUM_REQ.
module arbiter_n_to_1_request_rr_encoder
    import arbiter_n_to_1_request_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_winner,
    output logic [NUM_REQ-1:0] winner_onehot,
    output logic [IDX_W-1:0]   winner_index,
    output logic               any_valid
);

    logic        found;
    int unsigned pos;

    always_comb begin
        winner_onehot = '0;
        winner_index  = '0;
        found         = 1'b0;
        pos           = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            pos = (32'(last_winner) + k) % NUM_REQ;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!found && (i == pos) && req[i]) begin
                    found            = 1'b1;
                    winner_onehot[i] = 1'b1;
                    winner_index     = IDX_W'(i);
                end
            end
        end
    end

    assign any_valid = |req;

endmodule

// File: rtl/arbiter_n_to_1_request.sv
// Round-robin N-to-1 memory request arbiter with burst grant holding, route.from ID
// stamping and a registered, backpressured output stage.
module arbiter_n_to_1_request
    import arbiter_n_to_1_request_pkg::*;
#(
    parameter int unsigned NUM_MEMORY_REQUESTOR = 2,
    parameter int unsigned ID_LEVEL             = 1,
    parameter int unsigned STAMP_ID             = 1,
    parameter int unsigned MAX_BURST            = 4
) (
    input  logic                            ap_clk,
    input  logic                            ap_rst_n,
    input  memory_packet_t                  request_in [NUM_MEMORY_REQUESTOR],
    output logic [NUM_MEMORY_REQUESTOR-1:0] request_in_ready,
    input  logic                            request_out_ready,
    output memory_packet_t                  request_out,
    output logic [NUM_MEMORY_REQUESTOR-1:0] grant_out,
    output logic                            arbiter_busy
);

    localparam int unsigned N = NUM_MEMORY_REQUESTOR;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    arbiter_state_t   state, state_next;
    logic [N-1:0]     grant_next;
    logic [IDX_W-1:0] grant_index, grant_index_next;
    logic [IDX_W-1:0] last_winner, last_winner_next;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_next;

    logic [N-1:0]     req_valid;
    logic [N-1:0]     arb_req;
    logic [IDX_W-1:0] arb_ptr;
    logic [N-1:0]     arb_onehot;
    logic [IDX_W-1:0] arb_index;
    logic             arb_any;

    logic             can_load;
    logic             accept;
    logic             release_grant;
    payload_t         sel_payload;
    payload_t         out_payload;

    always_comb begin
        req_valid   = '0;
        sel_payload = '0;
        for (int unsigned i = 0; i < N; i++) begin
            req_valid[i] = request_in[i].valid;
            if (grant_out[i]) begin
                sel_payload = request_in[i].payload;
            end
        end
    end

    assign can_load         = ~request_out.valid | request_out_ready;
    assign request_in_ready = grant_out & {N{can_load}};
    assign accept           = |(req_valid & request_in_ready);
    assign release_grant    = (accept && (beat_cnt == CNT_LAST)) || !(|(req_valid & grant_out));

    // While granted, the current grantee is excluded and the scan starts just after it,
    // so a release can hand over directly. A lone requester is never excluded.
    assign arb_req = ((state == GRANT) && (N > 1)) ? (req_valid & ~grant_out) : req_valid;
    assign arb_ptr = (state == GRANT) ? grant_index : last_winner;

    arbiter_n_to_1_request_rr_encoder #(
        .NUM_REQ (N)
    ) u_rr_encoder (
        .req           (arb_req),
        .last_winner   (arb_ptr),
        .winner_onehot (arb_onehot),
        .winner_index  (arb_index),
        .any_valid     (arb_any)
    );

    always_comb begin
        state_next       = state;
        grant_next       = grant_out;
        grant_index_next = grant_index;
        last_winner_next = last_winner;
        beat_cnt_next    = beat_cnt;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    grant_next       = arb_onehot;
                    grant_index_next = arb_index;
                    beat_cnt_next    = '0;
                    state_next       = GRANT;
                end
            end
            GRANT: begin
                if (accept) begin
                    beat_cnt_next = beat_cnt + 8'd1;
                end
                if (release_grant) begin
                    last_winner_next = grant_index;
                    beat_cnt_next    = '0;
                    if (arb_any) begin
                        grant_next       = arb_onehot;
                        grant_index_next = arb_index;
                    end else begin
                        grant_next = '0;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                grant_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state       <= IDLE;
            grant_out   <= '0;
            grant_index <= '0;
            last_winner <= IDX_LAST;
            beat_cnt    <= '0;
        end else begin
            state       <= state_next;
            grant_out   <= grant_next;
            grant_index <= grant_index_next;
            last_winner <= last_winner_next;
            beat_cnt    <= beat_cnt_next;
        end
    end

    assign out_payload = ((STAMP_ID != 0) && (ID_LEVEL < ID_LEVEL_NONE))
                       ? stamp_route_from(sel_payload, ID_LEVEL, ID_W'(grant_out))
                       : sel_payload;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            request_out <= '0;
        end else if (can_load) begin
            request_out.valid <= accept;
            if (accept) begin
                request_out.payload <= out_payload;
            end
        end
    end

    assign arbiter_busy = (state != IDLE) | request_out.valid;

endmodule

// File: tb/tb_arbiter_n_to_1_request.sv
// Directed bench for the request arbiter: a 4-requester stamping instance and a
// 2-requester pass-through instance checked against a payload scoreboard.
module tb_arbiter_n_to_1_request;
    import arbiter_n_to_1_request_pkg::*;

    logic ap_clk;
    logic ap_rst_n;

    memory_packet_t req_a [4];
    logic [3:0]     rdy_in_a;
    logic           rdy_a;
    memory_packet_t out_a;
    logic [3:0]     grant_a;
    logic           busy_a;

    memory_packet_t req_b [2];
    logic [1:0]     rdy_in_b;
    logic           rdy_b;
    memory_packet_t out_b;
    logic [1:0]     grant_b;
    logic           busy_b;

    int n_cmp;
    int n_err;

    arbiter_n_to_1_request #(
        .NUM_MEMORY_REQUESTOR (4),
        .ID_LEVEL             (1),
        .STAMP_ID             (1),
        .MAX_BURST            (2)
    ) u_a (
        .ap_clk            (ap_clk),
        .ap_rst_n          (ap_rst_n),
        .request_in        (req_a),
        .request_in_ready  (rdy_in_a),
        .request_out_ready (rdy_a),
        .request_out       (out_a),
        .grant_out         (grant_a),
        .arbiter_busy      (busy_a)
    );

    arbiter_n_to_1_request #(
        .NUM_MEMORY_REQUESTOR (2),
        .ID_LEVEL             (3),
        .STAMP_ID             (0),
        .MAX_BURST            (4)
    ) u_b (
        .ap_clk            (ap_clk),
        .ap_rst_n          (ap_rst_n),
        .request_in        (req_b),
        .request_in_ready  (rdy_in_b),
        .request_out_ready (rdy_b),
        .request_out       (out_b),
        .grant_out         (grant_b),
        .arbiter_busy      (busy_b)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 4; i++) req_a[i] = '0;
        for (int i = 0; i < 2; i++) req_b[i] = '0;
        rdy_a = 1'b1;
        rdy_b = 1'b1;
    endtask

    // Returns at a falling edge with reset just released.
    task automatic do_reset();
        clear_inputs();
        ap_rst_n = 1'b0;
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
    endtask

    function automatic payload_t rand_payload();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[$bits(payload_t)-1:0];
    endfunction

    payload_t sb [$];
    payload_t exp_p;
    logic [1:0] acc_b;
    int n_beats;

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Reset state and single-requester latency with bundle stamping.
        do_reset();
        check_eq("rst_out_valid", out_a.valid, 1'b0);
        check_eq("rst_out_payload", out_a.payload, '0);
        check_eq("rst_grant", grant_a, 4'b0000);
        check_eq("rst_ready", rdy_in_a, 4'b0000);
        check_eq("rst_busy", busy_a, 1'b0);
        req_a[0].valid = 1'b1;
        req_a[0].payload.data = 32'h0000_00a0;
        req_a[0].payload.meta.route.from.id_bundle = 16'hffff;
        req_a[0].payload.meta.route.from.id_cu = 16'h1234;
        @(negedge ap_clk);
        check_eq("t1_grant", grant_a, 4'b0001);
        check_eq("t1_ready", rdy_in_a, 4'b0001);
        check_eq("t1_out_not_yet", out_a.valid, 1'b0);
        check_eq("t1_busy", busy_a, 1'b1);
        @(negedge ap_clk);
        check_eq("t1_out_valid", out_a.valid, 1'b1);
        check_eq("t1_out_data", out_a.payload.data, 32'h0000_00a0);
        check_eq("t1_id_bundle", out_a.payload.meta.route.from.id_bundle, 16'h0001);
        check_eq("t1_id_cu", out_a.payload.meta.route.from.id_cu, 16'h1234);
        req_a[0].valid = 1'b0;
        @(negedge ap_clk);
        check_eq("t1_release_grant", grant_a, 4'b0000);
        check_eq("t1_drain_valid", out_a.valid, 1'b0);
        check_eq("t1_idle_busy", busy_a, 1'b0);

        // All four requesters continuously valid: two beats each, index order, no bubbles.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[i].valid = 1'b1;
            req_a[i].payload.data = 32'(i);
        end
        @(negedge ap_clk);
        check_eq("fair_first_grant", grant_a, 4'b0001);
        @(negedge ap_clk);
        for (int k = 0; k < 16; k++) begin
            check_eq("fair_valid", out_a.valid, 1'b1);
            check_eq("fair_data", out_a.payload.data, 32'((k / 2) % 4));
            check_eq("fair_id", out_a.payload.meta.route.from.id_bundle, 16'(1 << ((k / 2) % 4)));
            @(negedge ap_clk);
        end
        clear_inputs();

        // Backpressure mid-burst: output held, requester stalled, nothing lost or repeated.
        do_reset();
        req_a[1].valid = 1'b1;
        req_a[1].payload.data = 32'h100;
        @(negedge ap_clk);
        check_eq("bp_grant", grant_a, 4'b0010);
        @(negedge ap_clk);
        check_eq("bp_first_data", out_a.payload.data, 32'h100);
        req_a[1].payload.data = 32'h101;
        rdy_a = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge ap_clk);
            check_eq("bp_hold_valid", out_a.valid, 1'b1);
            check_eq("bp_hold_data", out_a.payload.data, 32'h100);
            check_eq("bp_hold_ready", rdy_in_a, 4'b0000);
            check_eq("bp_hold_grant", grant_a, 4'b0010);
        end
        rdy_a = 1'b1;
        @(negedge ap_clk);
        check_eq("bp_second_valid", out_a.valid, 1'b1);
        check_eq("bp_second_data", out_a.payload.data, 32'h101);
        check_eq("bp_burst_end_grant", grant_a, 4'b0000);
        req_a[1].valid = 1'b0;
        @(negedge ap_clk);
        check_eq("bp_drain", out_a.valid, 1'b0);

        // Requester 2 drops valid after one beat; requester 3 takes over.
        do_reset();
        req_a[2].valid = 1'b1;
        req_a[2].payload.data = 32'h200;
        req_a[3].valid = 1'b1;
        req_a[3].payload.data = 32'h300;
        @(negedge ap_clk);
        check_eq("drop_grant2", grant_a, 4'b0100);
        @(negedge ap_clk);
        check_eq("drop_data2", out_a.payload.data, 32'h200);
        req_a[2].valid = 1'b0;
        @(negedge ap_clk);
        check_eq("drop_grant3", grant_a, 4'b1000);
        check_eq("drop_last_winner", u_a.last_winner, 4'd2);
        @(negedge ap_clk);
        check_eq("drop_out3_valid", out_a.valid, 1'b1);
        check_eq("drop_out3_id", out_a.payload.meta.route.from.id_bundle, 16'h0008);

        // Asynchronous reset with a beat in flight.
        #2 ap_rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", out_a.valid, 1'b0);
        check_eq("arst_grant", grant_a, 4'b0000);
        check_eq("arst_busy", busy_a, 1'b0);
        @(negedge ap_clk);
        req_a[0].valid = 1'b1;
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        check_eq("arst_first_winner", grant_a, 4'b0001);
        clear_inputs();

        // Pass-through instance: random traffic and backpressure against a scoreboard.
        do_reset();
        acc_b = '0;
        n_beats = 0;
        for (int cyc = 0; cyc < 3000 && n_beats < 100; cyc++) begin
            @(negedge ap_clk);
            for (int i = 0; i < 2; i++) begin
                if (!(req_b[i].valid && !acc_b[i])) begin
                    req_b[i].valid = ($urandom_range(0, 1) == 1);
                    req_b[i].payload = rand_payload();
                end
            end
            rdy_b = ($urandom_range(0, 3) != 0);
            #1;
            if (out_b.valid && rdy_b) begin
                if (sb.size() == 0) begin
                    check_eq("pt_underflow", sb.size(), 1);
                end else begin
                    exp_p = sb.pop_front();
                    check_eq("pt_beat", out_b.payload, exp_p);
                    n_beats++;
                end
            end
            for (int i = 0; i < 2; i++) begin
                acc_b[i] = req_b[i].valid && rdy_in_b[i];
                if (acc_b[i]) sb.push_back(req_b[i].payload);
            end
        end
        check_eq("pt_count", n_beats, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
